// File: rtl/adc_sample_controller.sv
// adc_sample_controller
// Periodically runs one conversion of a 12-bit serial ADC (16-bit frame,
// MSB first). Drives CS and SCLK from the system clock, shifts SDATA into
// b_reg on every SCLK rising edge and publishes the low DATA_BITS of the
// frame on data_Out with a one-cycle rx_done_tick.
//
// All pin outputs (CS, SCLK, rx_done_tick) are registered. They are computed
// from the next-state values, so they change on the same edge as the FSM
// state and never glitch on the pads.

module adc_sample_controller #(
   parameter int CLK_DIV       = 4,    // clk cycles per SCLK half-period (>= 1)
   parameter int SAMPLE_PERIOD = 200,  // clk cycles between conversion starts
   parameter int FRAME_BITS    = 16,   // SCLK periods per frame
   parameter int DATA_BITS     = 12    // result width (low bits of the frame)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  SDATA,
   output logic                  SCLK,
   output logic                  CS,
   output logic [FRAME_BITS-1:0] b_reg,
   output logic [DATA_BITS-1:0]  data_Out,
   output logic                  rx_done_tick,
   output logic                  busy,
   output logic                  overrun
);

   localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(FRAME_BITS + 1);

   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [DW-1:0]         div_q, div_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  half_hi_q, half_hi_d;   // 0: SCLK low half, 1: high half
   logic [FRAME_BITS-1:0] b_reg_q, b_reg_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  overrun_q, overrun_d;
   logic                  cs_q, cs_d;
   logic                  sclk_q, sclk_d;
   logic                  tick_q, tick_d;
   logic                  slot;

   // A sample slot is the cycle the running timer sits at zero.
   assign slot = enable && (timer_q == '0);

   // Sample-rate timer: free-runs while enabled, parked at zero otherwise so
   // that re-enabling produces a slot immediately.
   always_comb begin
      // NOTE: every variable gets a default before any branch; otherwise a
      // path that skips the assignment infers a latch.
      timer_d = timer_q;
      if (!enable) begin
         timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Conversion FSM: next state, counters, shift register, result and overrun.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      half_hi_d = half_hi_q;
      b_reg_d   = b_reg_q;
      data_d    = data_q;
      overrun_d = overrun_q;

      // A slot that finds a frame still in flight is dropped and remembered.
      if (slot && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (slot) begin
               state_d = SETUP;
               div_d   = '0;
            end
         end

         SETUP: begin
            // CS low with SCLK still high for one half-period before shifting.
            if (div_q == DIV_LAST) begin
               state_d   = SHIFT;
               div_d     = '0;
               bit_d     = '0;
               half_hi_d = 1'b0;
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!half_hi_q) begin
                  // Last cycle of the low half: SCLK rises on this edge, and
                  // SDATA has been stable since the preceding falling edge.
                  b_reg_d   = {b_reg_q[FRAME_BITS-2:0], SDATA};
                  half_hi_d = 1'b1;
               end else begin
                  half_hi_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = DONE;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Publish the result on the edge that enters DONE, so data_Out is
      // already valid in the cycle rx_done_tick is high.
      if (state_d == DONE) begin
         data_d = b_reg_q[DATA_BITS-1:0];
      end
   end

   // Pin outputs derived from the next state so they align with state_q.
   always_comb begin
      cs_d   = (state_d == IDLE) || (state_d == DONE);
      sclk_d = !((state_d == SHIFT) && !half_hi_d);
      tick_d = (state_d == DONE);
   end

   // State register; everything returns to the idle pin levels on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         div_q     <= '0;
         bit_q     <= '0;
         half_hi_q <= 1'b0;
         b_reg_q   <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge values, independent of statement order.
         state_q   <= state_d;
         timer_q   <= timer_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         half_hi_q <= half_hi_d;
         b_reg_q   <= b_reg_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         tick_q    <= tick_d;
      end
   end

   assign CS           = cs_q;
   assign SCLK         = sclk_q;
   assign b_reg        = b_reg_q;
   assign data_Out     = data_q;
   assign rx_done_tick = tick_q;
   assign busy         = (state_q != IDLE);
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_controller.sv
// Testbench for adc_sample_controller. Three instances cover the default
// configuration, a sample period shorter than a frame (overrun) and
// CLK_DIV=1. A behavioural ADC serves frames from a table; a monitor logs
// CS/SCLK windows and ticks, and each test task compares the logs against
// latencies and intervals derived arithmetically from the frame timing rules.

module tb_adc_sample_controller;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   logic        en    [3] = '{1'b0, 1'b0, 1'b0};
   logic        sdata [3] = '{1'b0, 1'b0, 1'b0};
   logic        sclk  [3];
   logic        cs    [3];
   logic        tick  [3];
   logic        busy  [3];
   logic        ovr   [3];
   logic [15:0] breg  [3];
   logic [11:0] dout  [3];

   int cdiv [3] = '{4, 4, 1};
   int sper [3] = '{200, 100, 40};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // ADC model and monitor state
   logic [15:0] frame_tab  [3][64];
   logic [15:0] cur        [3];
   int          idx        [3];
   int          n_frame    [3] = '{0, 0, 0};
   int          fall_cnt   [3] = '{0, 0, 0};
   int          low_start  [3] = '{0, 0, 0};
   int          last_low   [3] = '{0, 0, 0};
   int          last_falls [3] = '{0, 0, 0};
   int          stray      [3] = '{0, 0, 0};
   int          n_tick     [3] = '{0, 0, 0};
   int          tick_cyc   [3][64];
   int          tick_fidx  [3][64];
   logic [11:0] tick_data  [3][64];
   logic [15:0] tick_breg  [3][64];
   logic        prev_cs    [3] = '{1'b1, 1'b1, 1'b1};
   logic        prev_sclk  [3] = '{1'b1, 1'b1, 1'b1};

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   adc_sample_controller #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .FRAME_BITS(16), .DATA_BITS(12)) u_def (
      .clk(clk), .reset(reset), .enable(en[0]), .SDATA(sdata[0]), .SCLK(sclk[0]), .CS(cs[0]),
      .b_reg(breg[0]), .data_Out(dout[0]), .rx_done_tick(tick[0]), .busy(busy[0]), .overrun(ovr[0]));

   adc_sample_controller #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .FRAME_BITS(16), .DATA_BITS(12)) u_ovr (
      .clk(clk), .reset(reset), .enable(en[1]), .SDATA(sdata[1]), .SCLK(sclk[1]), .CS(cs[1]),
      .b_reg(breg[1]), .data_Out(dout[1]), .rx_done_tick(tick[1]), .busy(busy[1]), .overrun(ovr[1]));

   adc_sample_controller #(.CLK_DIV(1), .SAMPLE_PERIOD(40), .FRAME_BITS(16), .DATA_BITS(12)) u_fast (
      .clk(clk), .reset(reset), .enable(en[2]), .SDATA(sdata[2]), .SCLK(sclk[2]), .CS(cs[2]),
      .b_reg(breg[2]), .data_Out(dout[2]), .rx_done_tick(tick[2]), .busy(busy[2]), .overrun(ovr[2]));

   // ADC model plus monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int k;
         if (prev_cs[i] && !cs[i]) begin
            low_start[i] = cyc;
            fall_cnt[i]  = 0;
            cur[i]       = frame_tab[i][n_frame[i] % 64];
            idx[i]       = 15;
            n_frame[i]++;
         end
         if (prev_sclk[i] && !sclk[i]) begin
            if (cs[i] && prev_cs[i]) begin
               stray[i]++;
            end else begin
               fall_cnt[i]++;
               if (idx[i] >= 0) begin
                  sdata[i] = cur[i][idx[i]];
                  idx[i]--;
               end
            end
         end
         if (!prev_sclk[i] && sclk[i] && cs[i] && prev_cs[i]) stray[i]++;
         if (!prev_cs[i] && cs[i]) begin
            last_low[i]   = cyc - low_start[i];
            last_falls[i] = fall_cnt[i];
         end
         if (tick[i] === 1'b1) begin
            k               = n_tick[i] % 64;
            tick_cyc[i][k]  = cyc;
            tick_fidx[i][k] = n_frame[i] - 1;
            tick_data[i][k] = dout[i];
            tick_breg[i][k] = breg[i];
            n_tick[i]++;
         end
         prev_cs[i]   = cs[i];
         prev_sclk[i] = sclk[i];
      end
   end

   // Reference model: result is the low 12 bits of the frame the ADC sent;
   // a frame occupies slot..slot+33*CLK_DIV+1, so the next accepted slot is
   // the first multiple of SAMPLE_PERIOD at or after 33*CLK_DIV+2.
   function automatic logic [11:0] exp_data(int i, int fidx);
      logic [15:0] f;
      f = frame_tab[i][fidx % 64];
      return f[11:0];
   endfunction

   function automatic int exp_latency(int i);
      return 33 * cdiv[i] + 1;
   endfunction

   function automatic int exp_interval(int i);
      return ((33 * cdiv[i] + 2 + sper[i] - 1) / sper[i]) * sper[i];
   endfunction

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   task automatic cycles(int n);
      repeat (n) sync();
   endtask

   task automatic wait_ticks(int i, int target, int budget);
      int b = 0;
      while (n_tick[i] < target && b < budget) begin
         sync();
         b++;
      end
      checks++;
      if (n_tick[i] < target) begin
         errors++;
         $display("FAIL tick_timeout inst %0d: ticks %0d, required %0d", i, n_tick[i], target);
      end
   endtask

   task automatic wait_cs_fall(int i, int budget);
      int b  = 0;
      int nf = n_frame[i];
      while (n_frame[i] == nf && b < budget) begin
         sync();
         b++;
      end
      checks++;
      if (n_frame[i] == nf) begin
         errors++;
         $display("FAIL cs_fall_timeout inst %0d: no CS fall within %0d cycles", i, budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycles(3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({cs[i], sclk[i], tick[i], busy[i], ovr[i]} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl inst %0d: cs/sclk/tick/busy/ovr=%b, required 11000", i,
                     {cs[i], sclk[i], tick[i], busy[i], ovr[i]});
         end
         checks++;
         if (breg[i] !== 16'h0000 || dout[i] !== 12'h000) begin
            errors++;
            $display("FAIL reset_data inst %0d: b_reg=%h data_Out=%h, required 0000/000", i, breg[i], dout[i]);
         end
      end
      reset = 1'b0;
      cycles(5);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cs[i] !== 1'b1 || n_frame[i] != 0) begin
            errors++;
            $display("FAIL idle_disabled inst %0d: cs=%b frames=%0d, required 1/0", i, cs[i], n_frame[i]);
         end
      end
   endtask

   task automatic test_single_frame();
      int slot;
      frame_tab[0][0] = 16'h0A5C;
      frame_tab[0][1] = 16'h0FFF;
      frame_tab[0][2] = 16'h0000;
      frame_tab[0][3] = 16'h0800;
      en[0] = 1'b1;
      slot  = cyc;
      wait_ticks(0, 1, 300);
      checks++;
      if (low_start[0] - slot != 1) begin
         errors++;
         $display("FAIL cs_fall_latency: %0d, required 1", low_start[0] - slot);
      end
      checks++;
      if (tick_cyc[0][0] - slot != exp_latency(0)) begin
         errors++;
         $display("FAIL tick_latency: %0d, required %0d", tick_cyc[0][0] - slot, exp_latency(0));
      end
      checks++;
      if (last_low[0] != 33 * cdiv[0]) begin
         errors++;
         $display("FAIL cs_low_len: %0d, required %0d", last_low[0], 33 * cdiv[0]);
      end
      checks++;
      if (last_falls[0] != 16) begin
         errors++;
         $display("FAIL sclk_falls: %0d, required 16", last_falls[0]);
      end
      checks++;
      if (tick_data[0][0] !== 12'hA5C || tick_breg[0][0] !== 16'h0A5C) begin
         errors++;
         $display("FAIL single_data: data_Out=%h b_reg=%h, required A5C/0A5C", tick_data[0][0], tick_breg[0][0]);
      end
      sync();
      checks++;
      if (tick[0] !== 1'b0 || dout[0] !== 12'hA5C || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL tick_one_cycle: tick=%b data_Out=%h busy=%b, required 0/A5C/0", tick[0], dout[0], busy[0]);
      end
   endtask

   task automatic test_continuous();
      wait_ticks(0, 4, 700);
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (tick_cyc[0][k] - tick_cyc[0][k-1] != exp_interval(0)) begin
            errors++;
            $display("FAIL cont_interval %0d: %0d, required %0d", k, tick_cyc[0][k] - tick_cyc[0][k-1], exp_interval(0));
         end
         checks++;
         if (tick_data[0][k] !== exp_data(0, k)) begin
            errors++;
            $display("FAIL cont_data %0d: %h, required %h", k, tick_data[0][k], exp_data(0, k));
         end
      end
      checks++;
      if (ovr[0] !== 1'b0 || stray[0] != 0) begin
         errors++;
         $display("FAIL cont_clean: overrun=%b stray_sclk=%0d, required 0/0", ovr[0], stray[0]);
      end
   endtask

   task automatic test_enable_drop();
      int nt = n_tick[0];
      int nf = n_frame[0];
      wait_cs_fall(0, 300);
      cycles(cdiv[0] + 40);
      en[0] = 1'b0;
      wait_ticks(0, nt + 1, 300);
      checks++;
      if (tick_data[0][nt] !== exp_data(0, nf)) begin
         errors++;
         $display("FAIL drop_data: %h, required %h", tick_data[0][nt], exp_data(0, nf));
      end
      cycles(450);
      checks++;
      if (n_tick[0] != nt + 1 || n_frame[0] != nf + 1) begin
         errors++;
         $display("FAIL drop_quiet: ticks=%0d frames=%0d, required %0d/%0d", n_tick[0], n_frame[0], nt + 1, nf + 1);
      end
      checks++;
      if (cs[0] !== 1'b1 || sclk[0] !== 1'b1 || busy[0] !== 1'b0 || stray[0] != 0) begin
         errors++;
         $display("FAIL drop_idle: cs=%b sclk=%b busy=%b stray=%0d, required 1/1/0/0", cs[0], sclk[0], busy[0], stray[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int nt, nf2, slot;
      en[0] = 1'b1;
      wait_cs_fall(0, 20);
      cycles(cdiv[0] + 60);
      reset = 1'b1;
      #1;
      checks++;
      if ({cs[0], sclk[0], tick[0], busy[0]} !== 4'b1100) begin
         errors++;
         $display("FAIL midreset_ctrl: cs/sclk/tick/busy=%b, required 1100", {cs[0], sclk[0], tick[0], busy[0]});
      end
      checks++;
      if (dout[0] !== 12'h000 || breg[0] !== 16'h0000) begin
         errors++;
         $display("FAIL midreset_data: data_Out=%h b_reg=%h, required 000/0000", dout[0], breg[0]);
      end
      nt    = n_tick[0];
      en[0] = 1'b0;
      cycles(3);
      checks++;
      if (n_tick[0] != nt) begin
         errors++;
         $display("FAIL midreset_tick: ticks=%0d, required %0d", n_tick[0], nt);
      end
      reset = 1'b0;
      cycles(2);
      nf2   = n_frame[0];
      en[0] = 1'b1;
      slot  = cyc;
      wait_ticks(0, nt + 1, 300);
      en[0] = 1'b0;
      checks++;
      if (tick_fidx[0][nt] != nf2 || tick_data[0][nt] !== exp_data(0, nf2)) begin
         errors++;
         $display("FAIL postreset_data: frame %0d data %h, required frame %0d data %h",
                  tick_fidx[0][nt], tick_data[0][nt], nf2, exp_data(0, nf2));
      end
      checks++;
      if (tick_cyc[0][nt] - slot != exp_latency(0)) begin
         errors++;
         $display("FAIL postreset_latency: %0d, required %0d", tick_cyc[0][nt] - slot, exp_latency(0));
      end
      cycles(20);
   endtask

   task automatic test_overrun();
      int slot;
      checks++;
      if (ovr[1] !== 1'b0) begin
         errors++;
         $display("FAIL ovr_initial: %b, required 0", ovr[1]);
      end
      en[1] = 1'b1;
      slot  = cyc;
      cycles(sper[1] - 1);
      checks++;
      if (ovr[1] !== 1'b0) begin
         errors++;
         $display("FAIL ovr_early at slot+%0d: %b, required 0", cyc - slot, ovr[1]);
      end
      cycles(2);
      checks++;
      if (ovr[1] !== 1'b1) begin
         errors++;
         $display("FAIL ovr_set at slot+%0d: %b, required 1", cyc - slot, ovr[1]);
      end
      wait_ticks(1, 3, 800);
      en[1] = 1'b0;
      checks++;
      if (tick_cyc[1][0] - slot != exp_latency(1)) begin
         errors++;
         $display("FAIL ovr_latency: %0d, required %0d", tick_cyc[1][0] - slot, exp_latency(1));
      end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            checks++;
            if (tick_cyc[1][k] - tick_cyc[1][k-1] != exp_interval(1)) begin
               errors++;
               $display("FAIL ovr_interval %0d: %0d, required %0d", k, tick_cyc[1][k] - tick_cyc[1][k-1], exp_interval(1));
            end
         end
         checks++;
         if (tick_data[1][k] !== exp_data(1, k) || tick_fidx[1][k] != k) begin
            errors++;
            $display("FAIL ovr_data %0d: %h (frame %0d), required %h (frame %0d)", k, tick_data[1][k], tick_fidx[1][k], exp_data(1, k), k);
         end
      end
      checks++;
      if (ovr[1] !== 1'b1) begin
         errors++;
         $display("FAIL ovr_sticky: %b, required 1", ovr[1]);
      end
   endtask

   task automatic test_clk_div1();
      int slot;
      frame_tab[2][0] = 16'h0123;
      en[2] = 1'b1;
      slot  = cyc;
      wait_ticks(2, 1, 100);
      checks++;
      if (tick_cyc[2][0] - slot != exp_latency(2)) begin
         errors++;
         $display("FAIL div1_latency: %0d, required %0d", tick_cyc[2][0] - slot, exp_latency(2));
      end
      checks++;
      if (last_low[2] != 33 || last_falls[2] != 16) begin
         errors++;
         $display("FAIL div1_window: cs_low=%0d falls=%0d, required 33/16", last_low[2], last_falls[2]);
      end
      checks++;
      if (tick_data[2][0] !== 12'h123 || tick_breg[2][0] !== 16'h0123) begin
         errors++;
         $display("FAIL div1_data: data_Out=%h b_reg=%h, required 123/0123", tick_data[2][0], tick_breg[2][0]);
      end
      wait_ticks(2, 4, 200);
      en[2] = 1'b0;
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (tick_cyc[2][k] - tick_cyc[2][k-1] != exp_interval(2) || tick_data[2][k] !== exp_data(2, k)) begin
            errors++;
            $display("FAIL div1_run %0d: interval %0d data %h, required %0d/%h", k,
                     tick_cyc[2][k] - tick_cyc[2][k-1], tick_data[2][k], exp_interval(2), exp_data(2, k));
         end
      end
      checks++;
      if (ovr[2] !== 1'b0 || stray[2] != 0) begin
         errors++;
         $display("FAIL div1_clean: overrun=%b stray=%0d, required 0/0", ovr[2], stray[2]);
      end
   endtask

   task automatic test_back_to_back();
      int nt = n_tick[0];
      cycles($urandom_range(0, 20));
      en[0] = 1'b1;
      wait_ticks(0, nt + 5, 1200);
      en[0] = 1'b0;
      for (int k = nt; k < nt + 5; k++) begin
         if (k > nt) begin
            checks++;
            if (tick_cyc[0][k] - tick_cyc[0][k-1] != exp_interval(0)) begin
               errors++;
               $display("FAIL b2b_interval %0d: %0d, required %0d", k, tick_cyc[0][k] - tick_cyc[0][k-1], exp_interval(0));
            end
         end
         checks++;
         if (tick_data[0][k] !== exp_data(0, tick_fidx[0][k]) || tick_breg[0][k] !== frame_tab[0][tick_fidx[0][k]]) begin
            errors++;
            $display("FAIL b2b_data %0d: data_Out=%h b_reg=%h, required %h/%h", k, tick_data[0][k], tick_breg[0][k],
                     exp_data(0, tick_fidx[0][k]), frame_tab[0][tick_fidx[0][k]]);
         end
      end
      checks++;
      if (ovr[0] !== 1'b0 || stray[0] != 0) begin
         errors++;
         $display("FAIL b2b_clean: overrun=%b stray=%0d, required 0/0", ovr[0], stray[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 64; k++) begin
            frame_tab[i][k] = {4'h0, 12'($urandom_range(1, 4095))};
         end
      end
      test_reset();
      test_single_frame();
      test_continuous();
      test_enable_drop();
      test_reset_mid_frame();
      test_overrun();
      test_clk_div1();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
